// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//
// Drives the Basys3 4-digit 7-segment display for the snake game.
// A score is latched on request and converted to BCD by a sequential
// double-dabble (14 shift iterations). The four digits are then
// time-multiplexed, with optional leading-zero blanking and a
// game-over blink.
//
// Ports:
//   CLK100MHZ  in   system clock (100 MHz)
//   reset_n    in   asynchronous active-low reset
//   score[13:0] in  binary score; values above 9999 are shown as 9999
//   load       in   single-cycle request to latch and convert score
//   blink_en   in   level; 1 = blink the whole display
//   busy       out  conversion in progress; load is ignored while high
//   an[3:0]    out  digit enables, active-low, an[0] = ones digit
//   seg[7:0]   out  segments, active-low, {dp,g,f,e,d,c,b,a}; dp held off
module seg_scan_controller #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 250,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic        CLK100MHZ,
    input  logic        reset_n,
    input  logic [13:0] score,
    input  logic        load,
    input  logic        blink_en,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [13:0]   SCORE_MAX  = 14'd9999;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_reg, state_next;
    logic              accept, do_shift, do_copy;
    logic              busy_reg;
    logic [13:0]       bin_reg;
    logic [15:0]       bcd_reg;
    logic [15:0]       bcd_adj;
    logic [3:0]        iter_reg;
    logic [3:0][3:0]   digit_reg;

    logic [SW-1:0]     presc_reg;
    logic              scan_tick;
    logic [1:0]        idx_reg;
    logic [BW-1:0]     blink_cnt_reg;
    logic              blink_phase_reg;

    logic [3:0]        digit_zero;
    logic [3:0]        lz_run;
    logic [3:0]        blank;
    logic [3:0]        cur_digit;
    logic [7:0]        seg_code;
    logic [3:0]        an_reg;
    logic [7:0]        seg_reg;

    genvar gi;

    // ---------------------------------------------------------------
    // Converter FSM
    // ---------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // busy_reg lags the state by one cycle, so a load presented in the
    // cycle the FSM re-enters IDLE is still rejected.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load && !busy_reg) state_next = SHIFT;
            SHIFT:   if (iter_reg == 4'd13) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        do_shift = 1'b0;
        do_copy  = 1'b0;
        case (state_reg)
            IDLE:    accept   = load && !busy_reg;
            SHIFT:   do_shift = 1'b1;
            DONE:    do_copy  = 1'b1;
            default: ;
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg  <= 1'b0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
            digit_reg <= '0;
        end else begin
            busy_reg <= (state_reg != IDLE);
            if (accept) begin
                bin_reg  <= (score > SCORE_MAX) ? SCORE_MAX : score;
                bcd_reg  <= '0;
                iter_reg <= '0;
            end else if (do_shift) begin
                // Binary bits enter the BCD register MSB-first
                {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
                iter_reg           <= iter_reg + 4'd1;
            end
            // Display digits change in one step, never mid-conversion
            if (do_copy) begin
                digit_reg <= bcd_reg;
            end
        end
    end

    assign busy = busy_reg;

    // ---------------------------------------------------------------
    // Scan prescaler, digit index and blink timer (free-running)
    // ---------------------------------------------------------------
    assign scan_tick = (presc_reg == SCAN_LAST);

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg       <= '0;
            idx_reg         <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            presc_reg <= scan_tick ? '0 : presc_reg + 1'b1;
            if (scan_tick) begin
                idx_reg <= idx_reg + 2'd1;
            end
            // Holding the timer cleared while disabled guarantees that a
            // fresh blink always opens with a visible half-period.
            if (!blink_en) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= 1'b0;
            end else if (scan_tick) begin
                if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Leading-zero detection: digit k blanks when it and all higher
    // digits are zero; digit 0 always shows.
    // ---------------------------------------------------------------
    generate
        for (gi = 0; gi < 4; gi++) begin : g_zero
            assign digit_zero[gi] = (digit_reg[gi] == 4'd0);
        end
        assign lz_run[3] = digit_zero[3];
        for (gi = 0; gi < 3; gi++) begin : g_run
            assign lz_run[gi] = digit_zero[gi] & lz_run[gi+1];
        end
    endgenerate

    assign blank     = LZ_BLANK ? {lz_run[3:1], 1'b0} : 4'b0000;
    assign cur_digit = digit_reg[idx_reg];

    always_comb begin
        seg_code = 8'hFF;
        case (cur_digit)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    end

    // Output registers; a blanked digit keeps its anode on so every
    // digit gets the same duty cycle.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            an_reg  <= 4'b1111;
            seg_reg <= 8'hFF;
        end else if (blink_en && blink_phase_reg) begin
            an_reg  <= 4'b1111;
            seg_reg <= 8'hFF;
        end else begin
            an_reg  <= ~(4'b0001 << idx_reg);
            seg_reg <= blank[idx_reg] ? 8'hFF : seg_code;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

    logic        CLK100MHZ = 1'b0;
    logic        reset_n   = 1'b1;
    logic [13:0] score     = '0;
    logic        load      = 1'b0;
    logic        blink_en  = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seg;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;          // edges since the last reset release
    bit chk_en = 1'b0;       // check scan outputs on every tick
    bit dark   = 1'b0;       // expect the blink-off state on this tick
    logic [3:0][7:0] exp_seg = '0;   // expected segment code per digit

    always #5 CLK100MHZ = ~CLK100MHZ;

    seg_scan_controller #(
        .SCAN_DIV (4),
        .BLINK_DIV(2),
        .LZ_BLANK (1'b1)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset_n  (reset_n),
        .score    (score),
        .load     (load),
        .blink_en (blink_en),
        .busy     (busy),
        .an       (an),
        .seg      (seg)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the edge. Scan position after
    // release: output on edge n shows digit ((n-1)/4)%4.
    task automatic tick();
        int idx;
        logic [3:0] ea;
        @(posedge CLK100MHZ);
        #1;
        cyc++;
        if (chk_en) begin
            if (dark) begin
                check("blink_an", 16'(an), 16'h000F);
                check("blink_seg", 16'(seg), 16'h00FF);
            end else begin
                idx = ((cyc - 1) / 4) % 4;
                ea  = ~(4'b0001 << idx);
                check("scan_an", 16'(an), 16'(ea));
                check("scan_seg", 16'(seg), 16'(exp_seg[idx]));
            end
        end
    endtask

    // load sampled at edge 0; busy after edges 1..15, low after 16; new
    // digits shown from edge 16. Extra load pulses at edges g1..g3 must
    // be ignored (score is then 1111, which would show if accepted).
    task automatic do_load(input int s, input logic [3:0][7:0] ns,
                           input int g1, input int g2, input int g3);
        score = 14'(s);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        score = 14'd1111;
        for (int k = 1; k <= 16; k++) begin
            if (k == g1 || k == g2 || k == g3) load = 1'b1;
            if (k == 16) exp_seg = ns;
            tick();
            load = 1'b0;
            check("busy", 16'(busy), 16'(k <= 15));
        end
        $display("[TB] load score=%0d -> segs %h", s, ns);
    endtask

    initial begin
        // 1. reset
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_an", 16'(an), 16'h000F);
        check("rst_seg", 16'(seg), 16'h00FF);
        check("rst_busy", 16'(busy), 16'h0000);
        repeat (3) begin
            @(posedge CLK100MHZ);
            #1;
            check("rst_an", 16'(an), 16'h000F);
            check("rst_seg", 16'(seg), 16'h00FF);
        end
        reset_n = 1'b1;
        cyc     = 0;
        exp_seg = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
        chk_en  = 1'b1;
        repeat (16) tick();
        $display("[TB] reset release: display shows 0");

        // 2. 1234
        do_load(1234, {8'hF9, 8'hA4, 8'hB0, 8'h99}, 0, 0, 0);
        repeat (16) tick();

        // 3. 5000 with ignored repeat loads (edge 16 is the return-to-IDLE cycle)
        do_load(5000, {8'h92, 8'hC0, 8'hC0, 8'hC0}, 3, 10, 16);
        tick();
        check("busy_after_ignored", 16'(busy), 16'h0000);
        repeat (16) tick();

        // 4. saturation and blanking
        do_load(12000, {8'h90, 8'h90, 8'h90, 8'h90}, 0, 0, 0);
        repeat (16) tick();
        do_load(7, {8'hFF, 8'hFF, 8'hFF, 8'hF8}, 0, 0, 0);
        repeat (16) tick();

        // 5. blink with 42 displayed: align to just after a scan tick
        do_load(42, {8'hFF, 8'hFF, 8'h99, 8'hA4}, 0, 0, 0);
        while (cyc % 4 != 0) tick();
        for (int j = 1; j <= 32; j++) begin
            blink_en = !(j >= 13 && j <= 16);
            dark     = (j >= 9 && j <= 12) || (j >= 25);
            tick();
        end
        blink_en = 1'b0;
        dark     = 1'b0;
        repeat (8) tick();
        $display("[TB] blink sequence done");

        // 6. reset at cycle 7 of a 9876 conversion
        score = 14'd9876;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (7) tick();
        check("busy_mid", 16'(busy), 16'h0001);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_an", 16'(an), 16'h000F);
        check("abort_seg", 16'(seg), 16'h00FF);
        check("abort_busy", 16'(busy), 16'h0000);
        repeat (2) begin
            @(posedge CLK100MHZ);
            #1;
            check("abort_hold_an", 16'(an), 16'h000F);
            check("abort_hold_busy", 16'(busy), 16'h0000);
        end
        reset_n = 1'b1;
        cyc     = 0;
        exp_seg = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
        chk_en  = 1'b1;
        repeat (16) tick();
        do_load(9876, {8'h90, 8'h80, 8'hF8, 8'h82}, 0, 0, 0);
        repeat (16) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Owns the Basys3 4-digit 7-segment display (an/seg) for the snake game. It latches a binary score on request and converts it to BCD with a sequential double-dabble. It then time-multiplexes the four digits, with optional leading-zero blanking and a game-over blink. Sits between game logic and the top-level an/seg registers and replaces ad-hoc per-mode digit drivers.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
BLINK_DIV, 250, scan ticks per blink half-period (0.25 s at defaults); legal range >= 1.
LZ_BLANK, 1, 1 = blank leading zeros on digits 3..1; digit 0 is never blanked.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
score  input  14  binary score, values above 9999 saturate to 9999
load  input  1  single-cycle request to latch and convert score
blink_en  input  1  level input; 1 = blink whole display (game over)
busy  output  1  conversion in progress; load is ignored while high
an  output  4  digit enables, active-low, an[0] = ones (rightmost)
seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}; dp is always 1 (off)

Behaviour:
- Reset state (asynchronous, takes effect immediately on reset_n low):
  - an = 4'b1111, seg = 8'hFF, busy = 0.
  - Displayed digits = 0, conversion registers = 0.
  - Prescaler = 0, digit index = 0, blink counter = 0, blink phase = 0.
- Converter FSM has states IDLE, SHIFT, DONE.
  - IDLE: load=1 latches min(score,9999) and clears the BCD shift register, then goes to SHIFT. busy goes high on the next edge.
  - SHIFT: exactly 14 iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts left one bit, taking the next binary bit MSB-first.
  - After iteration 14 the FSM goes to DONE. DONE copies the 4 BCD nibbles to the displayed-digit registers in one cycle, clears busy and returns to IDLE.
  - Latency: load sampled at edge 0; busy is high after edges 1..15 and low after edge 16; new digits are visible from edge 16.
  - The displayed digits update atomically. The old value is shown for the whole conversion, so no partial values ever appear.
  - load while busy is ignored; no queuing. load in the same cycle the FSM returns to IDLE is also ignored, and is accepted from the next cycle.
  - score is sampled only at accept; later changes have no effect.
- Scan sequencing:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. At terminal count a scan tick fires and the digit index advances 0→1→2→3→0.
  - an and seg are registered from the current index and displayed digits, one cycle behind the index.
  - The first edge after reset release gives an = 4'b1110, seg = 8'hC0.
- Encoding (a..g active-low, dp = 1):
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99.
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
  - A nibble > 9 cannot occur; if forced, output FF.
- Leading-zero blank:
  - Applies when LZ_BLANK = 1 and k ≠ 0.
  - Digit k is blanked when it and every higher digit are 0.
  - A blanked digit gives seg = FF with its an bit still asserted, which keeps the duty cycle uniform.
- Blink:
  - The blink counter counts scan ticks 0..BLINK_DIV-1; at wrap the phase toggles.
  - When blink_en = 1 and phase = 1, an = 4'b1111 and seg = FF.
  - When blink_en = 0, phase is forced to 0 and the counter is cleared. Re-enabling blink therefore always starts with a visible half-period.
- Reset mid-conversion aborts it. Displayed digits return to 0 and busy = 0.
- Prescaler, index and blink keep running during conversion. Scan timing never depends on load activity.

Test Plan:
(Bench overrides SCAN_DIV=4, BLINK_DIV=2.)
1. Reset low for 3 cycles, then release:
   - during reset: an = 1111, seg = FF, busy = 0;
   - first edge after release: an = 1110, seg = C0;
   - with LZ_BLANK=1, digits 3..1 give seg = FF.
2. load=1 with score=1234 at edge 0:
   - busy is high after edges 1..15 and low after edge 16;
   - over one full rotation the outputs are an 1110/C..., namely {1110,99}, {1101,B0}, {1011,A4}, {0111,F9}.
3. Load score=5000:
   - repeat load pulses at cycles 3 and 10 are ignored;
   - the display reads 5000 with no blanking: digit 3 = 92, digits 2..0 = C0.
4. Saturation and blanking:
   - load score=12000 → display reads 9999 (four digits of 90);
   - load score=7 → digits 3..1 give FF and digit 0 gives F8.
5. blink_en=1 with 42 displayed:
   - display is visible for 2 scan ticks (8 cycles), then an = 1111 for 8 cycles, repeating;
   - dropping blink_en restores normal scanning on the next cycle.
6. Reset asserted at cycle 7 of a conversion of 9876:
   - an = 1111 and busy = 0 immediately;
   - after release the display shows 0 and a new load converts correctly.
